irq_controller: RTL

- Memory-mapped interrupt controller that sits between the I/O devices (timer, keys, switches) and the pipelined CPU.
- Latches per-source interrupt requests and applies a software mask and a global enable.
- Arbitrates pending sources with fixed priority (lowest index wins) and runs a request/acknowledge/done handshake with the CPU.
- Presents a stable source ID for the CPU to vector on.

---
 rtl/irq_pkg.sv | 26 ++
 rtl/irq_controller_prio_enc.sv | 31 +++
 rtl/irq_controller.sv | 138 +++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : irq_pkg                                                           |
// | Brief  : Shared types, CTRL field positions and default register addresses |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam int GIE_BIT   = 0;
    localparam int STATE_LSB = 1;
    localparam int ID_LSB    = 8;

    localparam logic [31:0] PEND_BASE_DEF = 32'hF000_0100;
    localparam logic [31:0] MASK_BASE_DEF = 32'hF000_0104;
    localparam logic [31:0] CTRL_BASE_DEF = 32'hF000_0108;

endpackage

`default_nettype wire

// File: rtl/irq_controller_prio_enc.sv
// +----------------------------------------------------------------------------+
// | Module : prio_enc                                                          |
// | Brief  : Combinational fixed-priority encoder, lowest set index wins       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 4
) (
    input  logic [NUM_SRC-1:0] req_i,
    output logic [ID_W-1:0]    idx_o,
    output logic               valid_o
);

    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = ID_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// +----------------------------------------------------------------------------+
// | Module : irq_controller                                                    |
// | Brief  : Edge-latched, maskable, fixed-priority interrupt controller       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module irq_controller
    import irq_pkg::*;
#(
    parameter int              BITS      = 32,
    parameter int              NUM_SRC   = 4,
    parameter int              ID_W      = 4,
    parameter logic [BITS-1:0] PEND_BASE = BITS'(PEND_BASE_DEF),
    parameter logic [BITS-1:0] MASK_BASE = BITS'(MASK_BASE_DEF),
    parameter logic [BITS-1:0] CTRL_BASE = BITS'(CTRL_BASE_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [BITS-1:0]    memAddr,
    input  logic [BITS-1:0]    dataBusIn,
    output logic [BITS-1:0]    dataBusOut,
    input  logic [NUM_SRC-1:0] irqIn,
    input  logic               intAck,
    input  logic               intDone,
    output logic               irq,
    output logic [ID_W-1:0]    irqId
);

    logic [NUM_SRC-1:0] irqPrev_q;
    logic [NUM_SRC-1:0] pend_q,  pend_d;
    logic [NUM_SRC-1:0] mask_q,  mask_d;
    logic               gie_q,   gie_d;
    irq_state_e         state_q, state_d;
    logic [ID_W-1:0]    curId_q, curId_d;

    logic               w_hit_pend, w_hit_mask, w_hit_ctrl;
    logic [NUM_SRC-1:0] w_rise, w_w1c, w_ack_clr, w_eligible;
    logic [ID_W-1:0]    w_winner;
    logic               w_any;
    logic               w_ack_take;
    logic [BITS-1:0]    w_ctrl;
    logic               w_unused_bus;

    assign w_hit_pend = (memAddr == PEND_BASE);
    assign w_hit_mask = (memAddr == MASK_BASE);
    assign w_hit_ctrl = (memAddr == CTRL_BASE);

    assign w_unused_bus = ^dataBusIn[BITS-1:NUM_SRC];

    assign w_rise     = irqIn & ~irqPrev_q;
    assign w_w1c      = (we && w_hit_pend) ? dataBusIn[NUM_SRC-1:0] : '0;
    assign w_ack_take = (state_q == REQ) && intAck;
    assign w_ack_clr  = w_ack_take ? (NUM_SRC'(1) << curId_q) : '0;

    // Rising edges are OR-ed in last so a same-cycle set beats any clear.
    assign pend_d = (pend_q & ~(w_w1c | w_ack_clr)) | w_rise;
    assign mask_d = (we && w_hit_mask) ? dataBusIn[NUM_SRC-1:0] : mask_q;
    assign gie_d  = (we && w_hit_ctrl) ? dataBusIn[GIE_BIT] : gie_q;

    assign w_eligible = gie_q ? (pend_q & mask_q) : '0;

    prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req_i   (w_eligible),
        .idx_o   (w_winner),
        .valid_o (w_any)
    );

    always_comb begin
        state_d = state_q;
        curId_d = curId_q;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    state_d = REQ;
                    curId_d = w_winner;
                end
            end
            REQ: begin
                if (intAck) begin
                    state_d = SERVICE;
                end else if (!w_eligible[curId_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (intDone) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irqPrev_q <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            state_q   <= IDLE;
            curId_q   <= '0;
        end else begin
            irqPrev_q <= irqIn;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
            state_q   <= state_d;
            curId_q   <= curId_d;
        end
    end

    assign irq   = (state_q == REQ);
    assign irqId = ((state_q == REQ) || (state_q == SERVICE)) ? curId_q : '0;

    always_comb begin
        w_ctrl                      = '0;
        w_ctrl[GIE_BIT]             = gie_q;
        w_ctrl[STATE_LSB +: 2]      = state_q;
        w_ctrl[ID_LSB +: ID_W]      = curId_q;
    end

    always_comb begin
        dataBusOut = '0;
        if (!we) begin
            if (w_hit_pend)      dataBusOut = BITS'(pend_q);
            else if (w_hit_mask) dataBusOut = BITS'(mask_q);
            else if (w_hit_ctrl) dataBusOut = w_ctrl;
        end
    end

endmodule

`default_nettype wire
